fd_segment_scan: RTL and testbench
==================================

# fd_segment_scan

Scan controller and segment tester for the FAST corner detector. Walks every interior reference pixel of the 180x120 grayscale frame in SRAM and drives the address-calculation stage with the reference address and the adjacency index sequence (17, 1..16). It consumes the returned pixel data, classifies the 16 Bresenham-circle points as brighter or darker than the centre, and reports a per-pixel corner decision with a running corner count.

## Interface
Parameters:
- THRESHOLD, 8'd20, intensity margin T for the brighter/darker test
- ARC_LEN, 9, contiguous circle points required for a corner (1..16)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle pulse; begins a frame scan when idle
- refAddr  out  15  reference pixel address to the address-calculation stage
- adjNumber  out  5  adjacency index: 0 idle, 17 centre, 1..16 circle points
- sramData  in  8  pixel read back; valid the cycle after the address is presented
- busy  out  1  high from the cycle after accepted start until done
- resultValid  out  1  one-cycle pulse per evaluated pixel
- isCorner  out  1  corner decision, qualified by resultValid
- resultAddr  out  15  reference address of the evaluated pixel
- cornerCount  out  15  corners found in the current or last scan
- done  out  1  one-cycle pulse after the last pixel's result

## Operation
- Scan region: rows 3..116, cols 3..176 (3-pixel margin), row-major; 114 x 174 = 19836 pixels.
- refAddr starts at 543 (row 3, col 3). Within a row it steps +1; after col 176 it steps +7 (col back to 3, row +1). The last pixel is 21056.
- States:
  - IDLE: adjNumber = 0, busy = 0. start goes to READ, resets row, col and refAddr, and clears cornerCount.
  - READ: 17 cycles, with adjNumber = 17, 1, 2, ... 16, one per cycle. refAddr is held constant.
  - WAIT: 1 cycle, adjNumber = 0, captures point 16.
  - EVAL: 1 cycle, adjNumber = 0. Asserts resultValid, isCorner and resultAddr. Goes to READ for the next pixel, or to IDLE with done after pixel 21056.
- Capture: the centre value c is registered from the data returned for index 17. For point k, bright[k] is 1 when p > c + T, and dark[k] is 1 when p < c - T.
- Comparison width: all compares are done in 9 bits unsigned. c + T never wraps, and c - T is treated as no-dark when c < T.
- Corner test: a circular run of at least ARC_LEN consecutive set bits in bright or in dark. Point 16 is adjacent to point 1 (wrap-around). Mixed bright/dark runs do not count.
- cornerCount increments in EVAL when isCorner = 1. It saturates at 32767 and holds its value after done until the next start.
- start while busy is ignored. start in the same cycle as done is also ignored; re-pulse from IDLE.
- Reset (any time, including mid-scan): returns to IDLE immediately, and all outputs go to 0 (refAddr 0, adjNumber 0, cornerCount 0).

## Timing
- start sampled high in IDLE at edge k: at edge k the outputs become refAddr = 543, adjNumber = 17, busy = 1.
- An address/index presented in cycle n returns sramData in cycle n+1, sampled at the end of n+1.
- Per pixel: 19 cycles (17 READ + WAIT + EVAL). resultValid fires 18 cycles after the pixel's adjNumber = 17 cycle.
- Full frame: done fires 19836 x 19 = 376884 cycles after the first READ cycle. busy drops in the same cycle that done pulses.
- isCorner and resultAddr are valid only while resultValid is high. Between pulses they hold their previous values.

## Test plan
- Flat frame, all pixels 100 -> 19836 resultValid pulses, each with isCorner = 0, then done; cornerCount = 0; first resultAddr = 543, last = 21056.
- Pixel (10,10) = 200, all others 100 -> exactly one corner, resultAddr = 1810 (dark mask 0xFFFF); cornerCount = 1.
- Centre 100 with circle points 13..16 and 1..5 at 150, others at 100 -> 9-run across the wrap, isCorner = 1. Set point 5 to 100 instead -> 8-run, isCorner = 0.
- Threshold edges with T = 20: c = 100, p = 120 -> not bright, p = 121 -> bright. c = 250, p = 255 -> not bright (no overflow). c = 10, p = 0 -> not dark (no underflow).
- Assert rst_n low mid-scan during READ -> adjNumber, refAddr, busy and cornerCount all 0 immediately. After release, start restarts at refAddr 543.
- start pulsed while busy -> no effect, the scan continues unchanged. After done, a new start clears cornerCount and rescans.

Source files
------------

// File: rtl/fd_segment_scan.sv
// FAST scan controller: walks interior pixels, fetches centre + 16 circle points, flags arcs.
// 19 cycles per pixel, result registered in EVAL; no backpressure, sramData must return one cycle after each address.
module fd_segment_scan #(
  parameter logic [7:0] THRESHOLD  = 8'd20,
  parameter int         ARC_LEN    = 9,
  parameter int         FRAME_COLS = 180,
  parameter int         FRAME_ROWS = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [14:0] refAddr,
  output logic [4:0]  adjNumber,
  input  logic [7:0]  sramData,
  output logic        busy,
  output logic        resultValid,
  output logic        isCorner,
  output logic [14:0] resultAddr,
  output logic [14:0] cornerCount,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, EVAL} state_t;

  localparam logic [14:0] FIRST_ADDR = 15'(3 * FRAME_COLS + 3);
  localparam logic [7:0]  LAST_ROW   = 8'(FRAME_ROWS - 4);
  localparam logic [7:0]  LAST_COL   = 8'(FRAME_COLS - 4);
  localparam logic [8:0]  T9         = {1'b0, THRESHOLD};

  state_t      state_q;
  logic [7:0]  row_q, col_q;
  logic [14:0] ref_q, raddr_q, count_q;
  logic [4:0]  adj_q, idx_q;
  logic [7:0]  c_q;
  logic [15:0] bright_q, dark_q;
  logic        busy_q, valid_q, corner_q, done_q;

  logic [15:0] bright_d, dark_d;
  logic        corner_d;
  logic [8:0]  pix9, hi9, lo9;
  logic [3:0]  bitpos;

  // Circular run search: doubling the mask lets a straight window cover the 16->1 wrap.
  function automatic logic has_run(input logic [15:0] m);
    logic [31:0] mm;
    logic        hit;
    logic        run;
    mm  = {m, m};
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run = 1'b1;
      for (int j = 0; j < ARC_LEN; j++) begin
        run = run & mm[i + j];
      end
      hit = hit | run;
    end
    return hit;
  endfunction

  // idx_q names the index whose data is on sramData this cycle.
  always_comb begin
    pix9     = {1'b0, sramData};
    hi9      = {1'b0, c_q} + T9;
    lo9      = {1'b0, c_q} - T9;
    bitpos   = idx_q[3:0] - 4'd1;
    bright_d = bright_q;
    dark_d   = dark_q;
    if (idx_q == 5'd17) begin
      bright_d = '0;
      dark_d   = '0;
    end else if (idx_q != 5'd0) begin
      bright_d[bitpos] = (pix9 > hi9);
      dark_d[bitpos]   = (c_q >= THRESHOLD) && (pix9 < lo9);
    end
    corner_d = has_run(bright_d) | has_run(dark_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      ref_q    <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      adj_q    <= '0;
      idx_q    <= '0;
      c_q      <= '0;
      bright_q <= '0;
      dark_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      corner_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= adj_q;
      bright_q <= bright_d;
      dark_q   <= dark_d;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      if (idx_q == 5'd17) begin
        c_q <= sramData;
      end
      case (state_q)
        IDLE: begin
          // done_q still high here means this is the done cycle; a start now is dropped.
          if (start && !done_q) begin
            state_q <= READ;
            row_q   <= 8'd3;
            col_q   <= 8'd3;
            ref_q   <= FIRST_ADDR;
            adj_q   <= 5'd17;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        READ: begin
          if (adj_q == 5'd17) begin
            adj_q <= 5'd1;
          end else if (adj_q == 5'd16) begin
            adj_q   <= 5'd0;
            state_q <= WAIT;
          end else begin
            adj_q <= adj_q + 5'd1;
          end
        end
        WAIT: begin
          state_q  <= EVAL;
          valid_q  <= 1'b1;
          corner_q <= corner_d;
          raddr_q  <= ref_q;
          if (corner_d && (count_q != 15'h7fff)) begin
            count_q <= count_q + 15'd1;
          end
        end
        EVAL: begin
          if ((row_q == LAST_ROW) && (col_q == LAST_COL)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= READ;
            adj_q   <= 5'd17;
            if (col_q == LAST_COL) begin
              col_q <= 8'd3;
              row_q <= row_q + 8'd1;
              ref_q <= ref_q + 15'd7;
            end else begin
              col_q <= col_q + 8'd1;
              ref_q <= ref_q + 15'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign refAddr     = ref_q;
  assign adjNumber   = adj_q;
  assign busy        = busy_q;
  assign resultValid = valid_q;
  assign isCorner    = corner_q;
  assign resultAddr  = raddr_q;
  assign cornerCount = count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fd_segment_scan.sv
// Directed bench for fd_segment_scan on a 180-wide, 14-row frame with a registered SRAM model.
module tb_fd_segment_scan;

  localparam int COLS = 180;
  localparam int ROWS = 14;
  localparam int NPIX = COLS * ROWS;
  localparam int LAST = 10 * COLS + 176;
  localparam int NINT = 8 * 174;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] refAddr, resultAddr, cornerCount;
  logic [4:0]  adjNumber;
  logic [7:0]  sramData;
  logic        busy, resultValid, isCorner, done;

  logic [7:0]  mem [0:NPIX-1];

  int checks   = 0;
  int failures = 0;
  int n_valid, n_corner, first_addr, last_addr, corner_addr;
  int watch_seen, watch_corner, saw_done, busy_at_done;

  always #5 clk = ~clk;

  fd_segment_scan #(
    .THRESHOLD (8'd20),
    .ARC_LEN   (9),
    .FRAME_COLS(COLS),
    .FRAME_ROWS(ROWS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .refAddr    (refAddr),
    .adjNumber  (adjNumber),
    .sramData   (sramData),
    .busy       (busy),
    .resultValid(resultValid),
    .isCorner   (isCorner),
    .resultAddr (resultAddr),
    .cornerCount(cornerCount),
    .done       (done)
  );

  // Radius-3 Bresenham circle, point 1 at top, clockwise, as row-major offsets.
  function automatic int ofs(input logic [4:0] k);
    case (k)
      5'd1:    ofs = -540;
      5'd2:    ofs = -539;
      5'd3:    ofs = -358;
      5'd4:    ofs = -177;
      5'd5:    ofs = 3;
      5'd6:    ofs = 183;
      5'd7:    ofs = 362;
      5'd8:    ofs = 541;
      5'd9:    ofs = 540;
      5'd10:   ofs = 539;
      5'd11:   ofs = 358;
      5'd12:   ofs = 177;
      5'd13:   ofs = -3;
      5'd14:   ofs = -183;
      5'd15:   ofs = -362;
      5'd16:   ofs = -541;
      default: ofs = 0;
    endcase
  endfunction

  always @(posedge clk) begin : sram_model
    int a;
    a = int'(refAddr) + ofs(adjNumber);
    if (a >= 0 && a < NPIX) sramData <= mem[a];
    else sramData <= 8'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) mem[i] = v;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_ref", 32'(refAddr), 32'd543);
    chk("start_adj", 32'(adjNumber), 32'd17);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scan(input int watch, input bit stop_at_watch, input int poke, input int budget);
    n_valid = 0; n_corner = 0; first_addr = -1; last_addr = -1; corner_addr = -1;
    watch_seen = 0; watch_corner = -1; saw_done = 0; busy_at_done = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = (cyc == poke);
      if (resultValid) begin
        if (n_valid == 0) first_addr = int'(resultAddr);
        n_valid++;
        last_addr = int'(resultAddr);
        if (isCorner) begin
          n_corner++;
          corner_addr = int'(resultAddr);
        end
        if (int'(resultAddr) == watch) begin
          watch_seen   = 1;
          watch_corner = int'(isCorner);
          if (stop_at_watch) begin
            start = 1'b0;
            return;
          end
        end
      end
      if (done) begin
        saw_done     = 1;
        busy_at_done = int'(busy);
        start        = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic ring_case(input string tag, input logic [15:0] mask, input logic [7:0] ring,
                           input logic [7:0] centre, input int exp);
    fill(8'd100);
    mem[560] = centre;
    for (int k = 1; k <= 16; k++) begin
      if (mask[k-1]) mem[560 + ofs(5'(k))] = ring;
    end
    start_pulse();
    scan(560, 1'b1, -1, 2000);
    chk({tag, "_seen"}, 32'(watch_seen), 32'd1);
    chk(tag, 32'(watch_corner), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill(8'd100);
    repeat (3) @(negedge clk);
    chk("rst_ref", 32'(refAddr), 32'd0);
    chk("rst_adj", 32'(adjNumber), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cornerCount), 32'd0);
    chk("rst_valid", 32'(resultValid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Single bright pixel at (10,10): dark on all 16 points, the only corner in the frame.
    mem[1810] = 8'd200;
    start_pulse();
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      chk("read_adj", 32'(adjNumber), 32'(k));
      chk("read_ref_hold", 32'(refAddr), 32'd543);
    end
    @(posedge clk);
    #1;
    chk("wait_adj", 32'(adjNumber), 32'd0);
    chk("wait_valid", 32'(resultValid), 32'd0);
    @(posedge clk);
    #1;
    chk("eval_valid", 32'(resultValid), 32'd1);
    chk("eval_addr", 32'(resultAddr), 32'd543);
    chk("eval_corner", 32'(isCorner), 32'd0);

    scan(-1, 1'b0, 5000, 27000);
    chk("spot_done", 32'(saw_done), 32'd1);
    chk("spot_nvalid", 32'(n_valid), 32'(NINT));
    chk("spot_first", 32'(first_addr), 32'd543);
    chk("spot_last", 32'(last_addr), 32'(LAST));
    chk("spot_ncorner", 32'(n_corner), 32'd1);
    chk("spot_caddr", 32'(corner_addr), 32'd1810);
    chk("spot_count", 32'(cornerCount), 32'd1);
    chk("spot_busy_at_done", 32'(busy_at_done), 32'd0);

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("donecyc_start_busy", 32'(busy), 32'd0);
    chk("donecyc_start_adj", 32'(adjNumber), 32'd0);
    chk("count_hold", 32'(cornerCount), 32'd1);

    mem[1810] = 8'd100;
    start_pulse();
    chk("restart_clears_count", 32'(cornerCount), 32'd0);
    scan(-1, 1'b0, -1, 27000);
    chk("flat_done", 32'(saw_done), 32'd1);
    chk("flat_nvalid", 32'(n_valid), 32'(NINT));
    chk("flat_last", 32'(last_addr), 32'(LAST));
    chk("flat_ncorner", 32'(n_corner), 32'd0);
    chk("flat_count", 32'(cornerCount), 32'd0);

    ring_case("wrap9", 16'hF01F, 8'd150, 8'd100, 1);
    @(negedge clk);
    chk("mid_adj_pre", 32'(adjNumber), 32'd17);
    chk("mid_cnt_pre", 32'(cornerCount >= 15'd1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_adj", 32'(adjNumber), 32'd0);
    chk("mid_rst_ref", 32'(refAddr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(cornerCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    ring_case("wrap8", 16'hF00F, 8'd150, 8'd100, 0);
    reset_pulse();
    ring_case("thr_p120", 16'hFFFF, 8'd120, 8'd100, 0);
    reset_pulse();
    ring_case("thr_p121", 16'hFFFF, 8'd121, 8'd100, 1);
    reset_pulse();
    ring_case("no_overflow", 16'hFFFF, 8'd255, 8'd250, 0);
    reset_pulse();
    ring_case("no_underflow", 16'hFFFF, 8'd0, 8'd10, 0);
    reset_pulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
